// File: rtl/w80386_pkg.sv
// Shared w80386 types and constants used by the prefetch queue.
package w80386_pkg;

    localparam logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DROP
    } prefetch_state_t;

    // Clear the low address bits so the address is bus-word aligned.
    function automatic logic [31:0] align_address(input logic [31:0] addr,
                                                  input int unsigned bus_bytes);
        return addr & ~(32'(bus_bytes) - 32'd1);
    endfunction

endpackage

// File: rtl/prefetch_byte_buffer.sv
// Circular byte queue: masked bus-word write, WINDOW-byte registered read, variable pop.
module prefetch_byte_buffer
    import w80386_pkg::*;
#(
    parameter int unsigned BUS_BYTES   = 4,
    parameter int unsigned QUEUE_DEPTH = 32,
    parameter int unsigned WINDOW      = 16,
    localparam int unsigned SKIP_W     = $clog2(BUS_BYTES),
    localparam int unsigned CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  logic [8*BUS_BYTES-1:0] i_data,
    input  logic [SKIP_W-1:0]      i_skip,
    input  logic [4:0]             i_consume_count,
    output byte_t [WINDOW-1:0]     o_instruction,
    output logic [4:0]             o_window_bytes,
    output logic                   o_consume_error,
    output logic [CNT_W-1:0]       o_count
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);

    byte_t              r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    byte_t [WINDOW-1:0] r_instruction;
    logic [4:0]         r_window_bytes;
    logic               r_consume_error;

    logic [CNT_W-1:0]   w_push_n;
    logic [CNT_W-1:0]   w_count_next;
    logic [4:0]         w_consumed;
    logic [4:0]         w_window_next;
    logic               w_over;
    logic               w_err_next;
    logic [PTR_W-1:0]   w_rd_next;
    logic [PTR_W-1:0]   w_wr_next;
    logic [PTR_W-1:0]   w_win_addr [WINDOW];
    logic [PTR_W-1:0]   w_win_off  [WINDOW];
    logic [SKIP_W-1:0]  w_win_sel  [WINDOW];
    byte_t [WINDOW-1:0] w_instruction_next;
    logic [BUS_BYTES-1:0] w_wr_en;
    logic [PTR_W-1:0]   w_wr_addr [BUS_BYTES];

    // Pointer, count and error next-state; flush empties the queue and ignores consume.
    always_comb begin
        w_push_n = '0;
        if (i_push && !i_flush) begin
            w_push_n = CNT_W'(BUS_BYTES) - CNT_W'(i_skip);
        end
        w_over     = i_consume_count > r_window_bytes;
        w_consumed = w_over ? r_window_bytes : i_consume_count;
        if (i_flush) begin
            w_count_next = '0;
            w_rd_next    = '0;
            w_wr_next    = '0;
            w_err_next   = 1'b0;
        end else begin
            w_count_next = r_count + w_push_n - CNT_W'(w_consumed);
            w_rd_next    = r_rd_ptr + PTR_W'(w_consumed);
            w_wr_next    = r_wr_ptr + PTR_W'(w_push_n);
            w_err_next   = w_over;
        end
        w_window_next = (w_count_next > CNT_W'(WINDOW)) ? 5'(WINDOW) : 5'(w_count_next);
    end

    // Only bytes at or above the skip offset of the bus word are written.
    always_comb begin
        for (int j = 0; j < int'(BUS_BYTES); j++) begin
            w_wr_en[j]   = i_push && !i_flush && (SKIP_W'(j) >= i_skip);
            w_wr_addr[j] = r_wr_ptr + PTR_W'(j) - PTR_W'(i_skip);
        end
    end

    // Next window; bytes being written this cycle are bypassed from the bus word.
    always_comb begin
        for (int i = 0; i < int'(WINDOW); i++) begin
            w_win_addr[i]         = w_rd_next + PTR_W'(i);
            w_win_off[i]          = w_win_addr[i] - r_wr_ptr;
            w_win_sel[i]          = SKIP_W'(w_win_off[i]) + i_skip;
            w_instruction_next[i] = '0;
            if (5'(i) < w_window_next) begin
                if (CNT_W'(w_win_off[i]) < w_push_n) begin
                    w_instruction_next[i] = i_data[{w_win_sel[i], 3'b000} +: 8];
                end else begin
                    w_instruction_next[i] = r_mem[w_win_addr[i]];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int j = 0; j < int'(BUS_BYTES); j++) begin
            if (w_wr_en[j]) begin
                r_mem[w_wr_addr[j]] <= i_data[8*j +: 8];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr        <= '0;
            r_wr_ptr        <= '0;
            r_count         <= '0;
            r_instruction   <= '0;
            r_window_bytes  <= '0;
            r_consume_error <= 1'b0;
        end else begin
            r_rd_ptr        <= w_rd_next;
            r_wr_ptr        <= w_wr_next;
            r_count         <= w_count_next;
            r_instruction   <= w_instruction_next;
            r_window_bytes  <= w_window_next;
            r_consume_error <= w_err_next;
        end
    end

    assign o_instruction   = r_instruction;
    assign o_window_bytes  = r_window_bytes;
    assign o_consume_error = r_consume_error;
    assign o_count         = r_count;

endmodule

// File: rtl/prefetch_queue.sv
// Code prefetch unit: bus fetch FSM with flush/drop handling feeding a byte queue window.
module prefetch_queue
    import w80386_pkg::*;
#(
    parameter int unsigned BUS_WIDTH     = 32,
    parameter int unsigned QUEUE_DEPTH   = 32,
    parameter int unsigned WINDOW        = 16,
    parameter logic [31:0] RESET_ADDRESS = w80386_pkg::RESET_ADDRESS
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 bus_vaild,
    input  logic                 bus_ready,
    output logic                 bus_write_enable,
    output logic [31:0]          bus_address,
    input  logic [BUS_WIDTH-1:0] bus_data,
    input  logic                 flush,
    input  logic [31:0]          flush_address,
    input  logic [4:0]           consume_count,
    output byte_t [WINDOW-1:0]   instruction,
    output logic [4:0]           window_bytes,
    output logic                 consume_error
);

    localparam int unsigned BUS_BYTES = BUS_WIDTH / 8;
    localparam int unsigned SKIP_W    = $clog2(BUS_BYTES);
    localparam int unsigned CNT_W     = $clog2(QUEUE_DEPTH) + 1;

    prefetch_state_t   r_state;
    logic              r_bus_vaild;
    logic [31:0]       r_bus_address;
    logic [31:0]       r_target;
    logic [SKIP_W-1:0] r_skip;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_free;
    logic [CNT_W-1:0]  w_push_n;
    logic [CNT_W-1:0]  w_free_after;
    logic [31:0]       w_flush_target;
    logic              w_push;

    always_comb begin
        w_push         = (r_state == FETCH) && bus_ready && !flush;
        w_free         = CNT_W'(QUEUE_DEPTH) - w_count;
        w_push_n       = CNT_W'(BUS_BYTES) - CNT_W'(r_skip);
        w_free_after   = w_free - w_push_n;
        w_flush_target = align_address(flush_address, BUS_BYTES);
    end

    // Fetch FSM; a pending request is never withdrawn, so a flush under wait goes through DROP.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bus_vaild   <= 1'b0;
            r_bus_address <= align_address(RESET_ADDRESS, BUS_BYTES);
            r_target      <= align_address(RESET_ADDRESS, BUS_BYTES);
            r_skip        <= RESET_ADDRESS[SKIP_W-1:0];
        end else if (flush) begin
            r_skip   <= flush_address[SKIP_W-1:0];
            r_target <= w_flush_target;
            if (!r_bus_vaild || bus_ready) begin
                r_state       <= FETCH;
                r_bus_vaild   <= 1'b1;
                r_bus_address <= w_flush_target;
            end else begin
                r_state <= DROP;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_free >= CNT_W'(BUS_BYTES)) begin
                        r_state     <= FETCH;
                        r_bus_vaild <= 1'b1;
                    end
                end
                FETCH: begin
                    if (bus_ready) begin
                        r_bus_address <= r_bus_address + 32'(BUS_BYTES);
                        r_skip        <= '0;
                        if (w_free_after >= CNT_W'(BUS_BYTES)) begin
                            r_state     <= FETCH;
                            r_bus_vaild <= 1'b1;
                        end else begin
                            r_state     <= IDLE;
                            r_bus_vaild <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (bus_ready) begin
                        r_state       <= FETCH;
                        r_bus_vaild   <= 1'b1;
                        r_bus_address <= r_target;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_bus_vaild <= 1'b0;
                end
            endcase
        end
    end

    prefetch_byte_buffer #(
        .BUS_BYTES  (BUS_BYTES),
        .QUEUE_DEPTH(QUEUE_DEPTH),
        .WINDOW     (WINDOW)
    ) u_buffer (
        .clock          (clock),
        .reset          (reset),
        .i_flush        (flush),
        .i_push         (w_push),
        .i_data         (bus_data),
        .i_skip         (r_skip),
        .i_consume_count(consume_count),
        .o_instruction  (instruction),
        .o_window_bytes (window_bytes),
        .o_consume_error(consume_error),
        .o_count        (w_count)
    );

    assign bus_vaild        = r_bus_vaild;
    assign bus_address      = r_bus_address;
    assign bus_write_enable = 1'b0;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: reset, flush alignment, fill/stall, drop, consume error, wrap.
module tb_prefetch_queue;
    import w80386_pkg::*;

    logic          clock;
    logic          reset;
    logic          bus_vaild;
    logic          bus_ready;
    logic          bus_write_enable;
    logic [31:0]   bus_address;
    logic [31:0]   bus_data;
    logic          flush;
    logic [31:0]   flush_address;
    logic [4:0]    consume_count;
    byte_t [15:0]  instruction;
    logic [4:0]    window_bytes;
    logic          consume_error;

    logic          use_fixed;
    logic [31:0]   fixed_word;
    int            checks;
    int            errors;

    prefetch_queue dut (
        .clock           (clock),
        .reset           (reset),
        .bus_vaild       (bus_vaild),
        .bus_ready       (bus_ready),
        .bus_write_enable(bus_write_enable),
        .bus_address     (bus_address),
        .bus_data        (bus_data),
        .flush           (flush),
        .flush_address   (flush_address),
        .consume_count   (consume_count),
        .instruction     (instruction),
        .window_bytes    (window_bytes),
        .consume_error   (consume_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Code memory model: the byte at linear address A reads as A[7:0].
    assign bus_data = use_fixed ? fixed_word
                    : {bus_address[7:0] + 8'd3, bus_address[7:0] + 8'd2,
                       bus_address[7:0] + 8'd1, bus_address[7:0]};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus_ready     = 1'b0;
        flush         = 1'b0;
        flush_address = '0;
        consume_count = '0;
        use_fixed     = 1'b0;
        fixed_word    = '0;
        tick();
        tick();

        check("rst_valid", 32'(bus_vaild), 32'd0);
        check("rst_addr", bus_address, 32'hFFFF_FFF0);
        check("rst_wbytes", 32'(window_bytes), 32'd0);
        check("rst_err", 32'(consume_error), 32'd0);
        check("rst_instr_lo", instruction[7:0], 64'h0);
        check("rst_instr_hi", instruction[15:8], 64'h0);

        // 1: first fetch after reset release
        reset     = 1'b0;
        bus_ready = 1'b1;
        tick();
        check("t1_valid", 32'(bus_vaild), 32'd1);
        check("t1_addr", bus_address, 32'hFFFF_FFF0);
        tick();
        check("t1_wbytes", 32'(window_bytes), 32'd4);
        check("t1_instr0", 32'(instruction[0]), 32'hF0);
        check("t1_addr_next", bus_address, 32'hFFFF_FFF4);

        // 2: unaligned flush keeps only the top byte of the first word
        flush         = 1'b1;
        flush_address = 32'h0000_1003;
        tick();
        check("t2_flush_wbytes", 32'(window_bytes), 32'd0);
        check("t2_flush_addr", bus_address, 32'h0000_1000);
        check("t2_flush_valid", 32'(bus_vaild), 32'd1);
        flush      = 1'b0;
        use_fixed  = 1'b1;
        fixed_word = 32'h4433_2211;
        tick();
        check("t2_wbytes", 32'(window_bytes), 32'd1);
        check("t2_instr0", 32'(instruction[0]), 32'h44);
        check("t2_instr1", 32'(instruction[1]), 32'h00);
        check("t2_addr_next", bus_address, 32'h0000_1004);
        bus_ready = 1'b0;
        use_fixed = 1'b0;

        // 3: fill to full, stall, one refetch after consume
        flush         = 1'b1;
        flush_address = 32'h0000_2000;
        bus_ready     = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("t3_full_valid", 32'(bus_vaild), 32'd0);
        check("t3_full_wbytes", 32'(window_bytes), 32'd16);
        check("t3_full_instr15", 32'(instruction[15]), 32'h0F);
        check("t3_full_addr", bus_address, 32'h0000_2020);
        tick();
        check("t3_stall_valid", 32'(bus_vaild), 32'd0);
        consume_count = 5'd4;
        tick();
        consume_count = 5'd0;
        check("t3_cons_valid", 32'(bus_vaild), 32'd0);
        check("t3_cons_instr0", 32'(instruction[0]), 32'h04);
        tick();
        check("t3_refetch_valid", 32'(bus_vaild), 32'd1);
        check("t3_refetch_addr", bus_address, 32'h0000_2020);
        tick();
        check("t3_after_valid", 32'(bus_vaild), 32'd0);
        check("t3_after_addr", bus_address, 32'h0000_2024);
        tick();
        check("t3_once_valid", 32'(bus_vaild), 32'd0);
        consume_count = 5'd16;
        tick();
        consume_count = 5'd0;
        bus_ready     = 1'b0;
        check("t3_tail_instr0", 32'(instruction[0]), 32'h14);
        check("t3_tail_instr15", 32'(instruction[15]), 32'h23);
        check("t3_tail_wbytes", 32'(window_bytes), 32'd16);
        tick();
        check("t3_pend_valid", 32'(bus_vaild), 32'd1);
        check("t3_pend_addr", bus_address, 32'h0000_2024);

        // 4: flush under a waiting request drops the old word
        flush         = 1'b1;
        flush_address = 32'h0000_3006;
        tick();
        flush = 1'b0;
        check("t4_drop_wbytes", 32'(window_bytes), 32'd0);
        check("t4_hold_addr0", bus_address, 32'h0000_2024);
        check("t4_hold_valid", 32'(bus_vaild), 32'd1);
        tick();
        check("t4_hold_addr1", bus_address, 32'h0000_2024);
        tick();
        check("t4_hold_addr2", bus_address, 32'h0000_2024);
        bus_ready = 1'b1;
        tick();
        check("t4_new_addr", bus_address, 32'h0000_3004);
        check("t4_discard_wbytes", 32'(window_bytes), 32'd0);
        check("t4_new_valid", 32'(bus_vaild), 32'd1);
        tick();
        check("t4_wbytes", 32'(window_bytes), 32'd2);
        check("t4_instr0", 32'(instruction[0]), 32'h06);
        check("t4_instr1", 32'(instruction[1]), 32'h07);
        bus_ready = 1'b0;

        // 5: over-consume with a same-cycle push
        flush         = 1'b1;
        flush_address = 32'h0000_4005;
        bus_ready     = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("t5_wbytes3", 32'(window_bytes), 32'd3);
        check("t5_err0", 32'(consume_error), 32'd0);
        consume_count = 5'd5;
        tick();
        consume_count = 5'd0;
        bus_ready     = 1'b0;
        check("t5_err", 32'(consume_error), 32'd1);
        check("t5_wbytes", 32'(window_bytes), 32'd4);
        check("t5_instr0", 32'(instruction[0]), 32'h08);
        check("t5_instr3", 32'(instruction[3]), 32'h0B);
        check("t5_instr4", 32'(instruction[4]), 32'h00);
        tick();
        check("t5_err_pulse", 32'(consume_error), 32'd0);

        // 6: address wrap at the top of the linear space
        flush         = 1'b1;
        flush_address = 32'hFFFF_FFFC;
        bus_ready     = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_addr_top", bus_address, 32'hFFFF_FFFC);
        tick();
        check("t6_addr_wrap", bus_address, 32'h0000_0000);
        tick();
        bus_ready = 1'b0;
        check("t6_wbytes", 32'(window_bytes), 32'd8);
        check("t6_instr0", 32'(instruction[0]), 32'hFC);
        check("t6_instr3", 32'(instruction[3]), 32'hFF);
        check("t6_instr4", 32'(instruction[4]), 32'h00);
        check("t6_instr7", 32'(instruction[7]), 32'h03);
        check("write_enable", 32'(bus_write_enable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
